// File: rtl/neuron_mac_pipe_pkg.sv
// Shared constants, FSM state type and arithmetic helpers for the neuron engine.
package neuron_mac_pipe_pkg;

  localparam int LANES_DEF = 16;
  localparam int DW_DEF    = 8;
  localparam int BW_DEF    = 8;
  localparam int BEATS_DEF = 49;
  localparam int ACCW_DEF  = 26;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Width of one beat's product sum: a (DW+1)-bit signed pixel times a DW-bit
  // signed weight, summed over LANES lanes.
  function automatic int psum_width(input int dw, input int lanes);
    return 2 * dw + $clog2(lanes) + 1;
  endfunction

  // Signed add of two 64-bit operands, clamped to the range of a w-bit
  // signed result. Operands are expected to be sign-extended narrower values.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int w);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi) begin
      return hi;
    end else if (s < lo) begin
      return lo;
    end
    return s;
  endfunction

  // True when the same add would have to be clamped.
  function automatic logic sat_hit(input logic signed [63:0] a,
                                   input logic signed [63:0] b,
                                   input int w);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return (s > hi) || (s < lo);
  endfunction

endpackage

// File: rtl/neuron_mac_pipe_mac_tree_reg.sv
// Stage 1: LANES pixel x weight multipliers, adder tree and registered psum.
module mac_tree_reg
  import neuron_mac_pipe_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int DW    = DW_DEF,
  parameter int PW    = psum_width(DW, LANES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  fire,
  input  logic [LANES*DW-1:0]   pixels,
  input  logic [LANES*DW-1:0]   weights,
  output logic signed [PW-1:0]  psum,
  output logic                  psum_valid
);

  logic signed [PW-1:0] prod [LANES];
  logic signed [PW-1:0] sum;

  // Pixels are unsigned (zero-extended), weights signed (sign-extended).
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [DW-1:0] pix;
    logic [DW-1:0] wt;
    assign pix      = pixels[gi*DW +: DW];
    assign wt       = weights[gi*DW +: DW];
    assign prod[gi] = $signed({{(PW-DW){1'b0}}, pix}) * $signed({{(PW-DW){wt[DW-1]}}, wt});
  end

  // Lane products summed; synthesis balances this into an adder tree.
  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      sum = sum + prod[i];
    end
  end

  // Register the beat's product sum with its valid flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      psum       <= '0;
      psum_valid <= 1'b0;
    end else if (clr) begin
      psum       <= '0;
      psum_valid <= 1'b0;
    end else begin
      psum_valid <= fire;
      if (fire) begin
        psum <= sum;
      end
    end
  end

endmodule

// File: rtl/neuron_mac_pipe.sv
// Neuron engine: accumulates BEATS beats of psums onto a bias, saturates,
// optionally applies ReLU and presents one activation over valid/ready.
module neuron_mac_pipe
  import neuron_mac_pipe_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int DW    = DW_DEF,
  parameter int BW    = BW_DEF,
  parameter int BEATS = BEATS_DEF,
  parameter int ACCW  = ACCW_DEF,
  parameter int RELU  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DW-1:0]     pixels,
  input  logic [LANES*DW-1:0]     weights,
  input  logic [BW-1:0]           bias,
  input  logic                    clr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACCW-1:0]  dout,
  output logic                    sat
);

  localparam int PW = psum_width(DW, LANES);
  localparam int CW = $clog2(BEATS + 1);

  state_t                state, state_next;
  logic [CW-1:0]         cnt;
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] acc_upd;
  logic signed [ACCW-1:0] final_val;
  logic signed [ACCW-1:0] bias_ext;
  logic signed [PW-1:0]  psum;
  logic                  psum_valid;
  logic                  accept;
  logic                  last_beat;
  logic                  clamp;
  logic signed [63:0]    acc_wide;
  logic signed [63:0]    psum_wide;

  // Ready is gated by reset and clr so nothing is taken during either.
  assign in_ready  = rst && !clr &&
                     ((state == ST_IDLE) || ((state == ST_ACCUM) && (cnt < CW'(BEATS))));
  assign accept    = in_valid && in_ready;
  // cnt is 0 in IDLE, so this also covers the single-beat image.
  assign last_beat = accept && (cnt == CW'(BEATS - 1));
  assign bias_ext  = {{(ACCW-BW){bias[BW-1]}}, bias};

  mac_tree_reg #(
    .LANES (LANES),
    .DW    (DW),
    .PW    (PW)
  ) u_mac (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .fire       (accept),
    .pixels     (pixels),
    .weights    (weights),
    .psum       (psum),
    .psum_valid (psum_valid)
  );

  // Stage-2 saturating accumulate and the ReLU applied to the final value.
  always_comb begin
    acc_wide  = 64'(acc);
    psum_wide = 64'(psum);
    acc_upd   = ACCW'(sat_add(acc_wide, psum_wide, ACCW));
    clamp     = sat_hit(acc_wide, psum_wide, ACCW);
    final_val = ((RELU != 0) && acc[ACCW-1]) ? '0 : acc;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; clr overrides everything.
  always_comb begin
    state_next = state;
    if (clr) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (accept) state_next = last_beat ? ST_DRAIN : ST_ACCUM;
        ST_ACCUM: if (last_beat) state_next = ST_DRAIN;
        ST_DRAIN: if (!psum_valid) state_next = ST_DONE;
        ST_DONE:  if (out_ready) state_next = ST_IDLE;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // Beat counter, accumulator, sticky saturation flag and output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      acc       <= '0;
      sat       <= 1'b0;
      dout      <= '0;
      out_valid <= 1'b0;
    end else if (clr) begin
      cnt       <= '0;
      acc       <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        cnt <= cnt + 1'b1;
      end
      if (accept && (state == ST_IDLE)) begin
        acc <= bias_ext;
        sat <= 1'b0;
      end else if (psum_valid) begin
        acc <= acc_upd;
        if (clamp) begin
          sat <= 1'b1;
        end
      end
      // Last psum has retired once DRAIN sees no valid psum.
      if ((state == ST_DRAIN) && !psum_valid) begin
        dout      <= final_val;
        out_valid <= 1'b1;
      end
      if ((state == ST_DONE) && out_ready) begin
        out_valid <= 1'b0;
        cnt       <= '0;
        sat       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_neuron_mac_pipe.sv
// Directed bench: three instances (default, RELU=0, ACCW=20) share one stream.
module tb_neuron_mac_pipe;

  localparam int LANES = 16;
  localparam int DW    = 8;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   clr = 1'b0;
  logic                   out_ready = 1'b0;
  logic [LANES*DW-1:0]    pixels = '0;
  logic [LANES*DW-1:0]    weights = '0;
  logic [7:0]             bias = '0;

  logic                   rdy_a, ov_a, sat_a;
  logic signed [25:0]     dout_a;
  logic                   rdy_b, ov_b, sat_b;
  logic signed [25:0]     dout_b;
  logic                   rdy_c, ov_c, sat_c;
  logic signed [19:0]     dout_c;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  neuron_mac_pipe u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a),
    .pixels(pixels), .weights(weights), .bias(bias), .clr(clr),
    .out_valid(ov_a), .out_ready(out_ready), .dout(dout_a), .sat(sat_a)
  );

  neuron_mac_pipe #(.RELU(0)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b),
    .pixels(pixels), .weights(weights), .bias(bias), .clr(clr),
    .out_valid(ov_b), .out_ready(out_ready), .dout(dout_b), .sat(sat_b)
  );

  neuron_mac_pipe #(.ACCW(20)) u_dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_c),
    .pixels(pixels), .weights(weights), .bias(bias), .clr(clr),
    .out_valid(ov_c), .out_ready(out_ready), .dout(dout_c), .sat(sat_c)
  );

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  function automatic logic [LANES*DW-1:0] fill(input logic [7:0] v);
    return {LANES{v}};
  endfunction

  // Presents nbeats identical beats; gap inserts one idle cycle after each accept.
  task automatic send_beats(input logic [LANES*DW-1:0] p, input logic [LANES*DW-1:0] w,
                            input logic [7:0] b, input int nbeats, input bit gap);
    int sent = 0;
    int guard = 0;
    while (sent < nbeats && guard < 1000) begin
      in_valid = 1'b1;
      pixels   = p;
      weights  = w;
      bias     = b;
      if (rdy_a) sent++;
      @(negedge clk);
      guard++;
      if (gap && sent < nbeats) begin
        in_valid = 1'b0;
        @(negedge clk);
        guard++;
      end
    end
    in_valid = 1'b0;
    chk("beats_accepted", sent, nbeats);
  endtask

  // Full image, latency check, result checks, optional output stall, handshake.
  task automatic run_image(input string tag,
                           input logic [LANES*DW-1:0] p, input logic [LANES*DW-1:0] w,
                           input logic [7:0] b, input bit gap, input int hold,
                           input longint ea, input longint sa,
                           input longint eb, input longint sb,
                           input longint ec, input longint sc);
    int lat = 0;
    send_beats(p, w, b, 49, gap);
    while (!ov_a && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 1) chk({tag, "_drain_in_ready"}, rdy_a, 0);
    end
    chk({tag, "_latency"}, lat, 2);
    chk({tag, "_ov_b"}, ov_b, 1);
    chk({tag, "_ov_c"}, ov_c, 1);
    chk({tag, "_dout_a"}, dout_a, ea);
    chk({tag, "_sat_a"}, sat_a, sa);
    chk({tag, "_dout_b"}, dout_b, eb);
    chk({tag, "_sat_b"}, sat_b, sb);
    chk({tag, "_dout_c"}, dout_c, ec);
    chk({tag, "_sat_c"}, sat_c, sc);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, ov_a, 1);
      chk({tag, "_hold_dout"}, dout_a, ea);
      chk({tag, "_hold_in_ready"}, rdy_a, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_valid_dropped"}, ov_a, 0);
    chk({tag, "_ready_again"}, rdy_a, 1);
  endtask

  logic [LANES*DW-1:0] ramp_p, ramp_w;
  int hits;

  initial begin
    for (int i = 0; i < LANES; i++) begin
      ramp_p[i*DW +: DW] = 8'(i + 1);
      ramp_w[i*DW +: DW] = 8'(i - 8);
    end

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", rdy_a, 0);
    chk("rst_out_valid", ov_a, 0);
    chk("rst_dout", dout_a, 0);
    chk("rst_sat", sat_a, 0);
    rst = 1'b1;
    #1;
    chk("post_rst_in_ready", rdy_a, 1);
    @(negedge clk);

    // All ones: 49*16 = 784
    run_image("ones", fill(8'd1), fill(8'd1), 8'd0, 1'b0, 0,
              784, 0, 784, 0, 784, 0);

    // Per-lane ramp: sum (i+1)(i-8), i=0..15 = 272 per beat; 49*272 + 10
    run_image("ramp", ramp_p, ramp_w, 8'd10, 1'b0, 0,
              13338, 0, 13338, 0, 13338, 0);

    // Large negative: 49*16*255*(-128) - 5; ReLU clamps, ACCW=20 saturates
    run_image("neg", fill(8'd255), fill(8'h80), 8'hFB, 1'b0, 0,
              0, 0, 64'sd49 * 16 * 255 * (-128) - 5, 0, 0, 1);

    // Large positive: 784*255*127 = 25389840; ACCW=20 clamps to 524287
    run_image("pos", fill(8'd255), fill(8'd127), 8'd0, 1'b0, 0,
              25389840, 0, 25389840, 0, 524287, 1);

    // Same data with gapped input and a 5-cycle output stall
    run_image("gap", fill(8'd255), fill(8'd127), 8'd0, 1'b1, 5,
              25389840, 0, 25389840, 0, 524287, 1);

    // Abort after 20 beats; the beat presented with clr is refused
    send_beats(fill(8'd1), fill(8'd1), 8'd0, 20, 1'b0);
    in_valid = 1'b1;
    clr = 1'b1;
    #1;
    chk("clr_in_ready", rdy_a, 0);
    @(negedge clk);
    clr = 1'b0;
    in_valid = 1'b0;
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ov_a || ov_b || ov_c) hits++;
    end
    chk("clr_no_valid", hits, 0);
    run_image("after_clr", fill(8'd1), fill(8'd0), 8'd3, 1'b0, 0,
              3, 0, 3, 0, 3, 0);

    // Reset mid-image
    send_beats(fill(8'd255), fill(8'd127), 8'd0, 10, 1'b0);
    rst = 1'b0;
    #1;
    chk("mid_rst_in_ready", rdy_a, 0);
    chk("mid_rst_out_valid", ov_a, 0);
    chk("mid_rst_dout", dout_a, 0);
    chk("mid_rst_sat_c", sat_c, 0);
    @(negedge clk);
    rst = 1'b1;
    hits = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ov_a) hits++;
    end
    chk("mid_rst_no_valid", hits, 0);
    run_image("fresh", fill(8'd1), fill(8'd1), 8'd0, 1'b0, 0,
              784, 0, 784, 0, 784, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout got=%0d expected=%0d", 0, 1);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
